pe_mem_streamer: RTL

Transmit-side counterpart of the per-PE memory block. It holds one word per PE, loaded through a write port. On start, it streams every word into the interconnect over a valid/ready handshake. Each word is tagged with its source PE index, a destination PE index derived from a configured shift within power-of-two PE groups, and the group size.

---
 rtl/pe_ic_pkg.sv | 31 +++
 rtl/pe_mem_bank.sv | 33 +++
 rtl/pe_mem_streamer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pe_ic_pkg.sv
// Shared definitions for the PE interconnect: streamer FSM states and the
// destination / group-size helpers that the receive side reuses.
package pe_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } stream_state_e;

  // Rotate src by shift inside its power-of-two group; bits above the group stay put.
  function automatic logic [31:0] dest_index(
    input logic [31:0] src,
    input logic [31:0] shift,
    input logic [31:0] group_size
  );
    logic [31:0] m;
    m = group_size - 32'd1;
    return (src & ~m) | ((src + shift) & m);
  endfunction

  function automatic logic is_legal_group_size(
    input logic [31:0] group_size,
    input logic [31:0] nof_pes
  );
    return (group_size != 32'd0) &&
           ((group_size & (group_size - 32'd1)) == 32'd0) &&
           (group_size <= nof_pes);
  endfunction

endpackage

// File: rtl/pe_mem_bank.sv
// One word per PE: registered write port, combinational read port with
// write-first bypass so a same-cycle write is visible to the reader.
module pe_mem_bank #(
  parameter int WORD_SIZE  = 256,
  parameter int NOF_PES    = 16,
  parameter int NOF_LEVELS = $clog2(NOF_PES)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [NOF_LEVELS-1:0] i_wr_index,
  input  logic [WORD_SIZE-1:0]  i_wr_data,
  input  logic [NOF_LEVELS-1:0] i_rd_index,
  output logic [WORD_SIZE-1:0]  o_rd_data
);

  logic [WORD_SIZE-1:0] r_mem [NOF_PES];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_index] <= i_wr_data;
    end
  end

  always_comb begin
    if (i_wr_en && (i_wr_index == i_rd_index)) begin
      o_rd_data = i_wr_data;
    end else begin
      o_rd_data = r_mem[i_rd_index];
    end
  end

endmodule

// File: rtl/pe_mem_streamer.sv
// Streams every PE memory word into the interconnect over valid/ready,
// tagging each word with its source PE, computed destination PE and group size.
module pe_mem_streamer
  import pe_ic_pkg::*;
#(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [NOF_LEVELS-1:0]       wr_index,
  input  logic [WORD_SIZE-1:0]        wr_data,
  input  logic                        start,
  input  logic [NOF_LEVELS-1:0]       shift,
  input  logic [GROUP_SIZE_WIDTH-1:0] group_size,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [WORD_SIZE-1:0]        tx_data,
  output logic [NOF_LEVELS-1:0]       tx_src_pe_index,
  output logic [NOF_LEVELS-1:0]       tx_dest_pe_index,
  output logic [GROUP_SIZE_WIDTH-1:0] tx_pe_group_size
);

  localparam logic [NOF_LEVELS-1:0] LAST_IDX = NOF_LEVELS'(NOF_PES - 1);
  localparam logic [NOF_LEVELS-1:0] ONE_IDX  = NOF_LEVELS'(1);

  stream_state_e               r_state;
  stream_state_e               w_next_state;
  logic [NOF_LEVELS-1:0]       r_ptr;
  logic [NOF_LEVELS-1:0]       r_shift;
  logic [GROUP_SIZE_WIDTH-1:0] r_gs;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_tx_valid;
  logic [WORD_SIZE-1:0]        r_tx_data;
  logic [NOF_LEVELS-1:0]       r_tx_dest;

  logic                        w_wr_en;
  logic                        w_legal;
  logic                        w_hs;
  logic                        w_last;
  logic [NOF_LEVELS-1:0]       w_rd_index;
  logic [WORD_SIZE-1:0]        w_rd_data;
  logic [NOF_LEVELS-1:0]       w_ld_shift;
  logic [GROUP_SIZE_WIDTH-1:0] w_ld_gs;
  logic [NOF_LEVELS-1:0]       w_ld_dest;

  // Memory is frozen for the whole pass, including the DONE cycle.
  assign w_wr_en = wr_en && (r_state == IDLE);

  pe_mem_bank #(
    .WORD_SIZE  (WORD_SIZE),
    .NOF_PES    (NOF_PES),
    .NOF_LEVELS (NOF_LEVELS)
  ) u_bank (
    .clk        (clk),
    .i_wr_en    (w_wr_en),
    .i_wr_index (wr_index),
    .i_wr_data  (wr_data),
    .i_rd_index (w_rd_index),
    .o_rd_data  (w_rd_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_rd_index   = '0;
    w_ld_shift   = r_shift;
    w_ld_gs      = r_gs;
    w_hs         = r_tx_valid && tx_ready;
    w_last       = w_hs && (r_ptr == LAST_IDX);
    w_legal      = is_legal_group_size(32'(group_size), 32'(NOF_PES));
    case (r_state)
      IDLE: begin
        w_ld_shift = shift;
        w_ld_gs    = group_size;
        if (start && w_legal) begin
          w_next_state = SEND;
        end else begin
          w_next_state = IDLE;
        end
      end
      SEND: begin
        w_rd_index = r_ptr + ONE_IDX;
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = SEND;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    w_ld_dest = NOF_LEVELS'(dest_index(32'(w_rd_index), 32'(w_ld_shift), 32'(w_ld_gs)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Output stage: loads the next entry on the same edge as a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_shift    <= '0;
      r_gs       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_tx_dest  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_legal) begin
            r_shift    <= shift;
            r_gs       <= group_size;
            r_ptr      <= '0;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rd_data;
            r_tx_dest  <= w_ld_dest;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        SEND: begin
          if (w_last) begin
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else if (w_hs) begin
            r_ptr     <= w_rd_index;
            r_tx_data <= w_rd_data;
            r_tx_dest <= w_ld_dest;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;
  assign tx_valid         = r_tx_valid;
  assign tx_data          = r_tx_data;
  assign tx_src_pe_index  = r_ptr;
  assign tx_dest_pe_index = r_tx_dest;
  assign tx_pe_group_size = r_gs;

endmodule
